// File: rtl/pipelined_adder_sweep_ctrl.sv
// pipelined_adder_sweep_ctrl: write/read sweep controller for a downstream adder/RAM stage.
// Writes 64 operand pairs, waits for the consumer's write pipeline to retire,
// reads the 64 sums back and (optionally) checks them against the expected sums.
// Build option: define SWEEP_CHECK_EN to include the read-back checker; without it
// q_in is ignored, err_cnt/first_err_addr stay 0 and pass reports 1 after every sweep.
module pipelined_adder_sweep_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] a_seed,
    input  logic [6:0] b_seed,
    input  logic [7:0] q_in,
    output logic       wen,
    output logic [5:0] waddr,
    output logic [6:0] a,
    output logic [6:0] b,
    output logic       ren,
    output logic [5:0] raddr,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [5:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_DRAIN,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [5:0] r_cnt;
    logic [5:0] w_cntNext;
    logic [6:0] r_aSeed;
    logic [6:0] r_bSeed;
    logic       w_accept;
    logic [6:0] w_aBase;
    logic [6:0] w_bBase;

    logic       w_wen;
    logic       w_ren;
    logic       w_busy;
    logic       w_done;
    logic [5:0] w_waddr;
    logic [5:0] w_raddr;
    logic [6:0] w_a;
    logic [6:0] w_b;
    logic [7:0] w_errNext;
    logic [5:0] w_firstNext;
    logic       w_passNext;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_aBase  = w_accept ? a_seed : r_aSeed;
    assign w_bBase  = w_accept ? b_seed : r_bSeed;

    // State register, phase counter and the seeds captured when a sweep is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_aSeed <= 7'd0;
            r_bSeed <= 7'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_cntNext;
            if (w_accept) begin
                r_aSeed <= a_seed;
                r_bSeed <= b_seed;
            end
        end
    end

    // Next-state logic; the counter restarts at 0 on every phase change
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (start) w_nextState = S_WRITE;
            S_WRITE: if (r_cnt == 6'd63) w_nextState = S_DRAIN;
            S_DRAIN: if (r_cnt == 6'd2) w_nextState = S_READ;
            S_READ:  if (r_cnt == 6'd63) w_nextState = S_FLUSH;
            S_FLUSH: w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
        if ((w_nextState != r_state) || (r_state == S_IDLE)) begin
            w_cntNext = 6'd0;
        end else begin
            w_cntNext = r_cnt + 6'd1;
        end
    end

    // Output logic computed from the upcoming state so registered outputs line up with the state
    always_comb begin
        w_wen   = (w_nextState == S_WRITE);
        w_ren   = (w_nextState == S_READ);
        w_busy  = (w_nextState == S_WRITE) || (w_nextState == S_DRAIN) ||
                  (w_nextState == S_READ)  || (w_nextState == S_FLUSH);
        w_done  = (w_nextState == S_DONE);
        w_waddr = waddr;
        w_a     = a;
        w_b     = b;
        w_raddr = raddr;
        if (w_wen) begin
            w_waddr = w_cntNext;
            w_a     = w_aBase + {1'b0, w_cntNext};
            w_b     = w_bBase + {w_cntNext, 1'b0};
        end
        if (w_ren) begin
            w_raddr = w_cntNext;
        end
    end

`ifdef SWEEP_CHECK_EN
    logic       r_chkValid;
    logic [5:0] r_chkAddr;
    logic [6:0] w_expA;
    logic [6:0] w_expB;
    logic [7:0] w_expected;
    logic       w_mismatch;

    // Remember which read was issued last cycle; its data arrives on q_in this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chkValid <= 1'b0;
            r_chkAddr  <= 6'd0;
        end else begin
            r_chkValid <= (r_state == S_READ);
            r_chkAddr  <= raddr;
        end
    end

    assign w_expA     = r_aSeed + {1'b0, r_chkAddr};
    assign w_expB     = r_bSeed + {r_chkAddr, 1'b0};
    assign w_expected = {1'b0, w_expA} + {1'b0, w_expB};
    assign w_mismatch = r_chkValid && (q_in != w_expected);

    // Error bookkeeping: saturating count, first failing address, verdict on entering DONE
    always_comb begin
        w_errNext   = err_cnt;
        w_firstNext = first_err_addr;
        w_passNext  = pass;
        if (w_accept) begin
            w_errNext   = 8'd0;
            w_firstNext = 6'd0;
            w_passNext  = 1'b0;
        end else begin
            if (w_mismatch) begin
                if (err_cnt != 8'hFF) begin
                    w_errNext = err_cnt + 8'd1;
                end
                if (err_cnt == 8'd0) begin
                    w_firstNext = r_chkAddr;
                end
            end
            if (w_nextState == S_DONE) begin
                w_passNext = (w_errNext == 8'd0);
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^q_in;

    // Without the checker every sweep is reported as passing
    always_comb begin
        w_errNext   = 8'd0;
        w_firstNext = 6'd0;
        w_passNext  = pass;
        if (w_accept) begin
            w_passNext = 1'b0;
        end else if (w_nextState == S_DONE) begin
            w_passNext = 1'b1;
        end
    end
`endif

    // Output registers; reset drives every output to 0 regardless of phase
    always_ff @(posedge clk) begin
        if (rst) begin
            wen            <= 1'b0;
            waddr          <= 6'd0;
            a              <= 7'd0;
            b              <= 7'd0;
            ren            <= 1'b0;
            raddr          <= 6'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 8'd0;
            first_err_addr <= 6'd0;
        end else begin
            wen            <= w_wen;
            waddr          <= w_waddr;
            a              <= w_a;
            b              <= w_b;
            ren            <= w_ren;
            raddr          <= w_raddr;
            busy           <= w_busy;
            done           <= w_done;
            pass           <= w_passNext;
            err_cnt        <= w_errNext;
            first_err_addr <= w_firstNext;
        end
    end

endmodule

// File: tb/tb_pipelined_adder_sweep_ctrl.sv
// Testbench for pipelined_adder_sweep_ctrl with an ideal one-cycle-latency RAM model
// that can corrupt addresses 5 and 40. Honours SWEEP_CHECK_EN like the design.
module tb_pipelined_adder_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] a_seed;
    logic [6:0] b_seed;
    logic [7:0] q_in;
    logic       wen;
    logic [5:0] waddr;
    logic [6:0] a;
    logic [6:0] b;
    logic       ren;
    logic [5:0] raddr;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [5:0] first_err_addr;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mem [64];
    bit         faultEn = 1'b0;

    int         doneCount;
    int         doneEdge;
    logic [6:0] a1, b1, a63, b63;
    logic [7:0] q1, qLast;
    logic       prevRen;

    pipelined_adder_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .a_seed(a_seed), .b_seed(b_seed),
        .q_in(q_in), .wen(wen), .waddr(waddr), .a(a), .b(b), .ren(ren),
        .raddr(raddr), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal consumer: stores a+b on write, returns the stored sum one cycle after a read
    initial q_in = 8'd0;
    always @(posedge clk) begin
        if (wen) mem[waddr] <= {1'b0, a} + {1'b0, b};
        if (ren) begin
            if (faultEn && raddr == 6'd5)       q_in <= 8'd0;
            else if (faultEn && raddr == 6'd40) q_in <= mem[raddr] + 8'd1;
            else                                q_in <= mem[raddr];
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".wen"}, wen, 0);
        checkOutput({tag, ".ren"}, ren, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".done"}, done, 0);
        checkOutput({tag, ".pass"}, pass, 0);
        checkOutput({tag, ".waddr"}, waddr, 0);
        checkOutput({tag, ".raddr"}, raddr, 0);
        checkOutput({tag, ".a"}, a, 0);
        checkOutput({tag, ".b"}, b, 0);
        checkOutput({tag, ".err_cnt"}, err_cnt, 0);
        checkOutput({tag, ".first_err_addr"}, first_err_addr, 0);
    endtask

    // Runs one sweep. Edges are numbered from the start-sampling edge as edge 1, so the
    // DONE cycle follows edge 133. rstAt asserts rst (together with start) after that edge.
    task automatic applyStimulus(input logic [6:0] aS, input logic [6:0] bS,
                                 input bit injectFaults, input int rstAt, input bit pokeStart);
        faultEn   = injectFaults;
        doneCount = 0;
        doneEdge  = 0;
        prevRen   = 1'b0;
        @(negedge clk);
        a_seed = aS;
        b_seed = bS;
        start  = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                start  = 1'b0;
                a_seed = ~aS;
                b_seed = aS ^ 7'h55;
                checkOutput("busyAfterStart", busy, 1);
                checkOutput("wenAfterStart", wen, 1);
            end
            if (wen && waddr == 6'd1)  begin a1 = a;  b1 = b;  end
            if (wen && waddr == 6'd63) begin a63 = a; b63 = b; end
            if (ren && raddr == 6'd1) q1 = q_in;
            if (prevRen && !ren) qLast = q_in;
            prevRen = ren;
            if (done) begin
                doneCount++;
                if (doneEdge == 0) doneEdge = n;
            end
            if (n == rstAt) begin
                rst   = 1'b1;
                start = 1'b1;
            end
            if (n == rstAt + 1) begin
                checkIdleOutputs("midReadReset");
                rst   = 1'b0;
                start = 1'b0;
                @(negedge clk);
                checkOutput("noResumeAfterReset.busy", busy, 0);
                break;
            end
            if (pokeStart) begin
                if (n == 66)  start = 1'b1;
                if (n == 67)  start = 1'b0;
                if (n == 133) start = 1'b1;
                if (n == 134) start = 1'b0;
                if (n == 68)  checkOutput("drainPokeIgnored.ren", ren, 1);
                if (n == 136) checkOutput("donePokeIgnored.busy", busy, 0);
            end
        end
        faultEn = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a_seed = 7'd0;
        b_seed = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        rst = 1'b0;

        $display("[TB] basic sweep, seeds 0/0");
        applyStimulus(7'd0, 7'd0, 1'b0, 999, 1'b0);
        checkOutput("basic.a63", a63, 63);
        checkOutput("basic.b63", b63, 126);
        checkOutput("basic.read63", qLast, 189);
        checkOutput("basic.doneEdge", doneEdge, 133);
        checkOutput("basic.doneCount", doneCount, 1);
        checkOutput("basic.pass", pass, 1);
        checkOutput("basic.err_cnt", err_cnt, 0);

        $display("[TB] wrap-around, seeds 127/127");
        applyStimulus(7'd127, 7'd127, 1'b0, 999, 1'b0);
        checkOutput("wrap.a1", a1, 0);
        checkOutput("wrap.b1", b1, 1);
        checkOutput("wrap.read0", q1, 254);
        checkOutput("wrap.pass", pass, 1);

        $display("[TB] fault injection at addresses 5 and 40");
        applyStimulus(7'd10, 7'd20, 1'b1, 999, 1'b0);
`ifdef SWEEP_CHECK_EN
        checkOutput("fault.err_cnt", err_cnt, 2);
        checkOutput("fault.first_err_addr", first_err_addr, 5);
        checkOutput("fault.pass", pass, 0);
`else
        checkOutput("fault.err_cnt", err_cnt, 0);
        checkOutput("fault.first_err_addr", first_err_addr, 0);
        checkOutput("fault.pass", pass, 1);
`endif
        checkOutput("fault.doneCount", doneCount, 1);

        $display("[TB] reset during READ cycle 20");
        applyStimulus(7'd3, 7'd9, 1'b0, 88, 1'b0);
        checkOutput("midReadReset.doneCount", doneCount, 0);
        applyStimulus(7'd3, 7'd9, 1'b0, 999, 1'b0);
        checkOutput("afterReset.pass", pass, 1);
        checkOutput("afterReset.err_cnt", err_cnt, 0);
        checkOutput("afterReset.doneCount", doneCount, 1);

        $display("[TB] start pulses during DRAIN and DONE");
        applyStimulus(7'h11, 7'h22, 1'b0, 999, 1'b1);
        checkOutput("poke.doneCount", doneCount, 1);
        checkOutput("poke.doneEdge", doneEdge, 133);
        checkOutput("poke.pass", pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_sweep_ctrl.md
PIPELINED_ADDER_SWEEP_CTRL -- requirements
Module: pipelined_adder_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset. All ports are listed below, clock and reset first.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset.
- start  in  1  sweep request.
- a_seed  in  7  operand A base.
- b_seed  in  7  operand B base.
- q_in  in  8  read data from the downstream adder/RAM stage.
- wen  out  1  write enable to the adder stage.
- waddr  out  6  write address.
- a  out  7  operand A.
- b  out  7  operand B.
- ren  out  1  read enable.
- raddr  out  6  read address.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  last sweep error-free.
- err_cnt  out  8  mismatch count.
- first_err_addr  out  6  address of the first mismatch.
REQ-002 All outputs SHALL be registered.

Function
REQ-003 The FSM SHALL have the states IDLE, WRITE, DRAIN, READ, FLUSH and DONE, with the following transitions:
- IDLE->WRITE when start=1 at a clock edge.
- WRITE->DRAIN after 64 WRITE cycles.
- DRAIN->READ after exactly 3 cycles.
- READ->FLUSH after 64 READ cycles.
- FLUSH->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-004 The seeds SHALL be latched on the edge that samples start; later seed changes SHALL have no effect until the next sweep.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 In WRITE cycle i (i=0..63), the outputs SHALL be: wen=1, waddr=i, a=(a_seed+i) mod 128, b=(b_seed+2i) mod 128.
- Outside WRITE: wen=0; waddr, a and b are held.
REQ-007 DRAIN SHALL last exactly 3 cycles with wen=0 and ren=0, so the 2-stage write pipeline of the consumer retires before the first read.
REQ-008 In READ cycle j (j=0..63), the outputs SHALL be ren=1 and raddr=j. Outside READ, ren=0.
REQ-009 expected(j) SHALL equal {1'b0,a_j}+{1'b0,b_j}, an 8-bit unsigned sum with no overflow, maximum 254.
REQ-010 The check timing SHALL be as follows:
- q_in for read j is valid in the cycle after READ cycle j.
- The checker SHALL compare q_in against expected(j) in that cycle, i.e. in READ cycles 1..63 and in FLUSH.
REQ-011 On each mismatch, err_cnt SHALL increment, saturating at 255.
REQ-012 On the first mismatch of a sweep, first_err_addr SHALL capture j; later mismatches SHALL leave it unchanged.
REQ-013 busy SHALL be 1 in WRITE, DRAIN, READ and FLUSH, and 0 otherwise.
REQ-014 done SHALL be 1 only in DONE, which starts 133 edges after the start-sampling edge.
REQ-015 pass SHALL be updated in DONE to (err_cnt==0) and held until the next start.
REQ-016 The sweep SHALL clear err_cnt, first_err_addr and pass to 0 on the edge that accepts start.
REQ-017 A start asserted in the DONE cycle SHALL be ignored; a start asserted in the following IDLE cycle SHALL be accepted.

Reset
REQ-018 rst=1 SHALL force the following values on the next edge, regardless of state, including mid-sweep:
- state=IDLE.
- wen, ren, busy, done and pass = 0.
- waddr, raddr, a, b, err_cnt and first_err_addr = 0.
REQ-019 rst SHALL take priority over start in the same cycle.
REQ-020 No partial sweep SHALL resume after reset.

Configuration
REQ-021 The macro SWEEP_CHECK_EN SHALL control the checker as follows:
- Defined: REQ-009 to REQ-012 and REQ-015 are implemented.
- Undefined: the comparator and counters are omitted, q_in is unused, err_cnt=0, first_err_addr=0, and pass=1 in DONE and held.
REQ-022 Stimulus sequencing and timing SHALL be identical in both builds.

Verification
REQ-023 Basic sweep: rst, then start with a_seed=0, b_seed=0, and an ideal RAM model -> the following responses:
- WRITE cycle 63 drives waddr=63, a=63, b=126.
- READ 63 returns 189.
- done pulses once at edge 133.
- pass=1, err_cnt=0.
REQ-024 Wrap-around: a_seed=127, b_seed=127 -> the following responses:
- Cycle i=1 drives a=0, b=1.
- expected(0)=254.
- pass=1.
REQ-025 Fault injection: the model corrupts address 5 (returns 0) and address 40 -> the following responses:
- err_cnt=2.
- first_err_addr=5.
- pass=0.
- Without SWEEP_CHECK_EN: pass=1, err_cnt=0.
REQ-026 Reset mid-READ: rst at READ cycle 20 -> the following responses:
- On the next edge all outputs are 0 and state is IDLE.
- A subsequent start runs a full sweep to pass=1.
REQ-027 Start while busy: start pulsed during DRAIN and again during DONE -> both are ignored and exactly one done pulse occurs.
